// File: rtl/pattern_scan_sequencer.sv
// Drives the pattern comparator: presents stream bytes with their pattern position,
// follows the comparator verdict and counts complete-pattern hits.
module pattern_scan_sequencer #(
  parameter int unsigned PATTERN_LEN = 4,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic               s_valid_i,
  input  logic [7:0]         s_data_i,
  output logic               s_ready_o,
  output logic [1:0]         abus_o,
  output logic [7:0]         dbus_o,
  input  logic               wren_i,
  output logic               match_o,
  output logic [COUNT_W-1:0] match_cnt_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {StIdle, StScan, StRetry} state_e;

  localparam logic [1:0] LastIdx = 2'(PATTERN_LEN - 1);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [7:0]           hold_q, hold_d;
  logic                 match_q, match_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      hold_q  <= 8'd0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    if (disarm_i) begin
      state_d = StIdle;
      idx_d   = 2'd0;
    end else if (arm_i) begin
      // A handshake accepted this cycle is consumed but its verdict is ignored.
      state_d = StScan;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StScan: begin
          if (s_valid_i) begin
            if (wren_i) begin
              if (idx_q == LastIdx) begin
                idx_d   = 2'd0;
                match_d = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
              end else begin
                idx_d = idx_q + 2'd1;
              end
            end else if (idx_q != 2'd0) begin
              // Failing byte gets a second look as a potential first pattern byte.
              hold_d  = s_data_i;
              idx_d   = 2'd0;
              state_d = StRetry;
            end
          end
        end
        StRetry: begin
          idx_d   = (wren_i && PATTERN_LEN > 1) ? 2'd1 : 2'd0;
          state_d = StScan;
        end
        default: begin
          state_d = StIdle;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    s_ready_o = (state_q == StScan);
    busy_o    = (state_q != StIdle);
    abus_o    = (state_q == StScan) ? idx_q : 2'd0;
    unique case (state_q)
      StScan:  dbus_o = s_data_i;
      StRetry: dbus_o = hold_q;
      default: dbus_o = 8'd0;
    endcase
  end

  assign match_o     = match_q;
  assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_pattern_scan_sequencer.sv
// Randomized scoreboard bench: a byte-level pattern model predicts hits and bus activity
// for two sequencers (wide and 2-bit hit counters) driven by the same stream.
module tb_pattern_scan_sequencer;

  localparam int LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, arm, disarm, s_valid;
  logic [7:0] s_data;
  logic [7:0] pat [LEN];

  logic        rdy_a, rdy_b, match_a, match_b, busy_a, busy_b, wren_a, wren_b;
  logic [1:0]  abus_a, abus_b;
  logic [7:0]  dbus_a, dbus_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  // Comparator models
  assign wren_a = (dbus_a == pat[abus_a]);
  assign wren_b = (dbus_b == pat[abus_b]);

  pattern_scan_sequencer #(.PATTERN_LEN(LEN), .COUNT_W(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .disarm_i(disarm), .s_valid_i(s_valid),
    .s_data_i(s_data), .s_ready_o(rdy_a), .abus_o(abus_a), .dbus_o(dbus_a), .wren_i(wren_a),
    .match_o(match_a), .match_cnt_o(cnt_a), .busy_o(busy_a)
  );

  pattern_scan_sequencer #(.PATTERN_LEN(LEN), .COUNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .disarm_i(disarm), .s_valid_i(s_valid),
    .s_data_i(s_data), .s_ready_o(rdy_b), .abus_o(abus_b), .dbus_o(dbus_b), .wren_i(wren_b),
    .match_o(match_b), .match_cnt_o(cnt_b), .busy_o(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q_a[$];
  int q_b[$];

  // Reference model: armed flag, bytes of pattern matched so far, pending re-test byte.
  bit     m_armed = 0;
  bit     m_pend  = 0;
  int     m_pos   = 0;
  int     m_held  = 0;
  int     m_cnt_a = 0;
  int     m_cnt_b = 0;
  int     n_hits  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic step(input bit r, input bit a, input bit d, input bit v, input logic [7:0] b);
    bit   exp_rdy;
    int   exp_abus, exp_dbus;
    @(negedge clk);
    rst = r; arm = a; disarm = d; s_valid = v; s_data = b;
    #1;
    exp_rdy  = m_armed && !m_pend;
    exp_abus = exp_rdy ? m_pos : 0;
    exp_dbus = exp_rdy ? int'(b) : (m_armed ? m_held : 0);
    chk("s_ready", int'(rdy_a), int'(exp_rdy));
    chk("abus", int'(abus_a), exp_abus);
    chk("dbus", int'(dbus_a), exp_dbus);
    chk("busy", int'(busy_a), int'(m_armed));
    chk("match_cnt16", int'(cnt_a), m_cnt_a);
    chk("match_cnt2", int'(cnt_b), m_cnt_b);
    chk("s_ready_b", int'(rdy_b), int'(exp_rdy));
    // Advance model to the state after the coming edge.
    if (r) begin
      m_armed = 0; m_pend = 0; m_pos = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (d) begin
      m_armed = 0; m_pend = 0; m_pos = 0;
    end else if (a) begin
      m_armed = 1; m_pend = 0; m_pos = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (m_armed && m_pend) begin
      m_pos  = (m_held == int'(pat[0]) && LEN > 1) ? 1 : 0;
      m_pend = 0;
    end else if (m_armed && v) begin
      if (b == pat[m_pos]) begin
        m_pos++;
        if (m_pos == LEN) begin
          m_pos = 0;
          n_hits++;
          if (m_cnt_a < 65535) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
          q_a.push_back(m_cnt_a);
          q_b.push_back(m_cnt_b);
        end
      end else if (m_pos > 0) begin
        m_held = int'(b);
        m_pos  = 0;
        m_pend = 1;
      end
    end
  endtask

  task automatic feed(input logic [7:0] b);
    step(0, 0, 0, 1, b);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic feed_pat();
    for (int i = 0; i < LEN; i++) feed(pat[i]);
  endtask

  // Monitor: every cycle a DUT match must coincide with a queued expected hit.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (match_a) begin
        if (q_a.size() == 0) chk("unexpected_match16", 1, 0);
        else begin e = q_a.pop_front(); chk("hit_cnt16", int'(cnt_a), e); end
      end else begin
        chk("missed_match16", q_a.size(), 0);
        if (q_a.size() != 0) void'(q_a.pop_front());
      end
      if (match_b) begin
        if (q_b.size() == 0) chk("unexpected_match2", 1, 0);
        else begin e = q_b.pop_front(); chk("hit_cnt2", int'(cnt_b), e); end
      end else begin
        chk("missed_match2", q_b.size(), 0);
        if (q_b.size() != 0) void'(q_b.pop_front());
      end
    end
  end

  initial begin
    int hits_before;
    logic [7:0] byte_v;
    int k;
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h7E; pat[3] = 8'h01;
    rst = 1; arm = 0; disarm = 0; s_valid = 0; s_data = 8'h00;
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 1, 8'hA5);
    idle_n(2);

    // Clean pattern, then retry case, then gaps mid-pattern.
    step(0, 1, 0, 0, 8'h00);
    feed_pat();
    idle_n(2);
    feed(8'hA5); feed(8'h3C); feed(8'hA5); feed(8'h3C); feed(8'h7E); feed(8'h01);
    idle_n(2);
    feed(8'hA5); idle_n(3); feed(8'h3C); feed(8'h7E); feed(8'h01);
    idle_n(2);

    // Disarm at idx 2 keeps the count; rearm clears it.
    feed(8'hA5); feed(8'h3C);
    step(0, 0, 1, 1, 8'h7E);
    feed_pat();
    idle_n(1);
    step(0, 1, 1, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    feed_pat();
    idle_n(1);

    // Five hits: 2-bit counter saturates at 3.
    hits_before = n_hits;
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) feed_pat();
    idle_n(2);
    chk("five_hits", n_hits - hits_before, 5);
    chk("cnt2_saturated", int'(cnt_b), 3);
    chk("cnt16_five", int'(cnt_a), 5);

    // Reset during retry.
    feed(8'hA5); feed(8'h3C); feed(8'h00);
    step(1, 0, 0, 1, 8'hA5);
    feed(8'hA5);
    idle_n(1);

    // Randomized phase.
    step(0, 1, 0, 0, 8'h00);
    for (int c = 0; c < 4000; c++) begin
      k = $urandom_range(0, 5);
      byte_v = (k < 4) ? pat[k] : ((k == 4) ? pat[m_pos] : 8'($urandom));
      step($urandom_range(0, 511) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 127) == 0, $urandom_range(0, 3) != 0, byte_v);
      if (!m_armed && $urandom_range(0, 7) == 0) step(0, 1, 0, 0, 8'h00);
    end
    idle_n(3);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
